// File: rtl/overflow_event_reporter.sv
// overflow_event_reporter: numbers indicator samples, counts overflow events and queues {data, index} records
module overflow_event_reporter #(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 16,
  parameter int DEPTH     = 4,
  parameter int EDGE_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_overflow,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [DATA_W-1:0] rec_data,
  output logic [CNT_W-1:0]  rec_index,
  output logic [CNT_W-1:0]  ovf_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic              overrun
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] MAX = '1;
  logic [DATA_W+CNT_W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] idx;
  logic prev_flag, empty, full, pop, evt, push, drop;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign rec_valid = !empty;
  assign pop = rec_valid && rec_ready;
  assign evt = in_valid && in_overflow && (EDGE_MODE == 0 || !prev_flag);
  // a pop in the same cycle frees the slot the push lands in
  assign push = evt && (!full || pop);
  assign drop = evt && !push;
  assign {rec_data, rec_index} = rec_valid ? mem[rd_ptr[AW-1:0]] : '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= {in_data, idx};
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      idx        <= '0;
      prev_flag  <= 1'b0;
      ovf_count  <= '0;
      drop_count <= '0;
      overrun    <= 1'b0;
    end else begin
      if (in_valid) begin
        idx       <= idx + 1'b1;
        prev_flag <= in_overflow;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (evt && ovf_count != MAX) ovf_count <= ovf_count + 1'b1;
      if (drop) begin
        if (drop_count != MAX) drop_count <= drop_count + 1'b1;
        overrun <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_overflow_event_reporter.sv
// tb_overflow_event_reporter: directed checks of both event modes, backpressure, full-FIFO bypass and reset
module tb_overflow_event_reporter;
  logic clk = 0, rst_n = 0, clear = 0, in_valid = 0, in_overflow = 0, rec_ready = 0;
  logic [7:0] in_data = 0;
  logic rv0, ov0, rv1, ov1;
  logic [7:0] rd0, rd1;
  logic [15:0] ri0, oc0, dc0, ri1, oc1, dc1;
  logic [23:0] q0[$], q1[$];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  overflow_event_reporter #(.EDGE_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_overflow(in_overflow), .rec_valid(rv0), .rec_ready(rec_ready), .rec_data(rd0),
    .rec_index(ri0), .ovf_count(oc0), .drop_count(dc0), .overrun(ov0));

  overflow_event_reporter #(.EDGE_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_overflow(in_overflow), .rec_valid(rv1), .rec_ready(rec_ready), .rec_data(rd1),
    .rec_index(ri1), .ovf_count(oc1), .drop_count(dc1), .overrun(ov1));

  always @(negedge clk) begin
    if (rv0 && rec_ready) q0.push_back({rd0, ri0});
    if (rv1 && rec_ready) q1.push_back({rd1, ri1});
  end

  task automatic drive(input logic v, input logic o, input logic [7:0] d);
    in_valid = v;
    in_overflow = o;
    in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 0;
    clear = 0;
    rec_ready = 0;
    in_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rv0, rd0, ri0, oc0, dc0, ov0} !== '0) begin
      errors++;
      $display("FAIL reset_mode0: got %h exp 0", {rv0, rd0, ri0, oc0, dc0, ov0});
    end
    checks++;
    if ({rv1, rd1, ri1, oc1, dc1, ov1} !== '0) begin
      errors++;
      $display("FAIL reset_mode1: got %h exp 0", {rv1, rd1, ri1, oc1, dc1, ov1});
    end
    rst_n = 1;
    q0.delete();
    q1.delete();
  endtask

  task automatic test_ramp;
    logic [23:0] e0 [3];
    logic [23:0] e1 [2];
    e0 = '{{8'd10, 16'd10}, {8'd11, 16'd11}, {8'd200, 16'd200}};
    e1 = '{{8'd10, 16'd10}, {8'd200, 16'd200}};
    rec_ready = 1;
    for (int i = 0; i < 256; i++) drive(1, i == 10 || i == 11 || i == 200, 8'(i));
    repeat (3) drive(0, 0, 0);
    checks++;
    if (q0.size() != 3) begin
      errors++;
      $display("FAIL ramp0_count: got %0d exp 3", q0.size());
    end else for (int i = 0; i < 3; i++) begin
      checks++;
      if (q0[i] !== e0[i]) begin
        errors++;
        $display("FAIL ramp0_rec%0d: got %h exp %h", i, q0[i], e0[i]);
      end
    end
    checks++;
    if (q1.size() != 2) begin
      errors++;
      $display("FAIL ramp1_count: got %0d exp 2", q1.size());
    end else for (int i = 0; i < 2; i++) begin
      checks++;
      if (q1[i] !== e1[i]) begin
        errors++;
        $display("FAIL ramp1_rec%0d: got %h exp %h", i, q1[i], e1[i]);
      end
    end
    checks++;
    if ({oc0, dc0, oc1, dc1} !== {16'd3, 16'd0, 16'd2, 16'd0}) begin
      errors++;
      $display("FAIL ramp_counts: got %h exp 0003000000020000", {oc0, dc0, oc1, dc1});
    end
  endtask

  task automatic test_backpressure;
    test_reset();
    for (int i = 0; i < 6; i++) drive(1, 1, 8'hA0 + 8'(i));
    drive(0, 0, 0);
    checks++;
    if ({rv0, ov0, oc0, dc0, rd0, ri0} !== {1'b1, 1'b1, 16'd6, 16'd2, 8'hA0, 16'd0}) begin
      errors++;
      $display("FAIL bp_full: got %h exp %h", {rv0, ov0, oc0, dc0, rd0, ri0},
               {1'b1, 1'b1, 16'd6, 16'd2, 8'hA0, 16'd0});
    end
    repeat (3) drive(0, 0, 0);
    checks++;
    if ({rd0, ri0} !== {8'hA0, 16'd0}) begin
      errors++;
      $display("FAIL bp_stable: got %h exp a00000", {rd0, ri0});
    end
    rec_ready = 1;
    repeat (6) drive(0, 0, 0);
    checks++;
    if (q0.size() != 4) begin
      errors++;
      $display("FAIL bp_count: got %0d exp 4", q0.size());
    end else for (int i = 0; i < 4; i++) begin
      checks++;
      if (q0[i] !== {8'hA0 + 8'(i), 16'(i)}) begin
        errors++;
        $display("FAIL bp_rec%0d: got %h exp %h", i, q0[i], {8'hA0 + 8'(i), 16'(i)});
      end
    end
    checks++;
    if ({rv0, ov0, dc0} !== {1'b0, 1'b1, 16'd2}) begin
      errors++;
      $display("FAIL bp_after: got %h exp %h", {rv0, ov0, dc0}, {1'b0, 1'b1, 16'd2});
    end
  endtask

  task automatic test_full_bypass;
    rec_ready = 0;
    clear = 1;
    drive(0, 0, 0);
    clear = 0;
    checks++;
    if ({rv0, oc0, dc0, ov0} !== '0) begin
      errors++;
      $display("FAIL clear: got %h exp 0", {rv0, oc0, dc0, ov0});
    end
    q0.delete();
    for (int i = 0; i < 4; i++) drive(1, 1, 8'hB0 + 8'(i));
    rec_ready = 1;
    drive(1, 1, 8'hB4);
    checks++;
    if ({rv0, ov0, oc0, dc0, rd0} !== {1'b1, 1'b0, 16'd5, 16'd0, 8'hB1}) begin
      errors++;
      $display("FAIL bypass: got %h exp %h", {rv0, ov0, oc0, dc0, rd0},
               {1'b1, 1'b0, 16'd5, 16'd0, 8'hB1});
    end
    repeat (5) drive(0, 0, 0);
    checks++;
    if (q0.size() != 5 || q0[4] !== {8'hB4, 16'd4} || q0[0] !== {8'hB0, 16'd0}) begin
      errors++;
      $display("FAIL bypass_drain: got n=%0d first=%h last=%h exp n=5 first=b00000 last=b40004",
               q0.size(), q0.size() > 0 ? q0[0] : 24'h0, q0.size() > 4 ? q0[4] : 24'h0);
    end
  endtask

  task automatic test_reset_midstream;
    rec_ready = 0;
    for (int i = 0; i < 3; i++) drive(1, 1, 8'hC0 + 8'(i));
    checks++;
    if (rv0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_queued: got %b exp 1", rv0);
    end
    rst_n = 0;
    drive(1, 1, 8'h77);
    checks++;
    if ({rv0, oc0, dc0, ov0, rv1, oc1} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got %h exp 0", {rv0, oc0, dc0, ov0, rv1, oc1});
    end
    rst_n = 1;
    drive(1, 1, 8'h55);
    checks++;
    if ({rv0, rd0, ri0, oc0} !== {1'b1, 8'h55, 16'd0, 16'd1}) begin
      errors++;
      $display("FAIL mid_first: got %h exp %h", {rv0, rd0, ri0, oc0}, {1'b1, 8'h55, 16'd0, 16'd1});
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_backpressure();
    test_full_bypass();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
